// File: rtl/ft245_fifo_bridge_pkg.sv
// Shared types and helpers for the FT245 async-FIFO bridge.
package ft245_fifo_bridge_pkg;

    // Pin-protocol sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_TURN     = 3'd2,
        ST_WR_SETUP = 3'd3,
        ST_WR       = 3'd4
    } state_t;

    // Round-robin pointer values: the side that wins the next tie.
    localparam logic RR_RX = 1'b0;
    localparam logic RR_TX = 1'b1;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ft245_fifo_bridge_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
// Push and pop may coincide at any level; a push into a full buffer is
// accepted only when a pop frees the slot in the same cycle.
module ft245_fifo_bridge_sync_fifo
    import ft245_fifo_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_pop,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_empty,
    output logic [clog2(DEPTH):0]   o_level
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  w_full;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_empty   = (r_level == '0);
    assign w_full    = (r_level == LW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // Storage array, written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/ft245_fifo_bridge.sv
// FT245 async-FIFO pin sequencer bridging to buffered RX/TX streams.
// Stream handshakes: a word moves on a rising clk edge where valid and ready
// are both high; valid never depends on ready, and data is stable while
// valid is high and ready is low.
module ft245_fifo_bridge
    import ft245_fifo_bridge_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int RX_DEPTH    = 16,
    parameter int TX_DEPTH    = 16,
    parameter int SYNC_STAGES = 2,
    parameter int RD_PULSE    = 3,
    parameter int WR_PULSE    = 3,
    parameter int TURN_CYC    = 1,
    parameter int SIWU_IDLE   = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      iFIFO_RXF_n,
    output logic                      oFIFO_RD_n,
    input  logic                      iFIFO_TXE_n,
    output logic                      oFIFO_WR_n,
    input  logic [DATA_WIDTH-1:0]     iFIFO_DATA,
    output logic [DATA_WIDTH-1:0]     oFIFO_DATA,
    output logic                      oFIFO_OE_n,
    output logic                      oFIFO_SIWU_n,
    output logic [DATA_WIDTH-1:0]     oRX_DATA,
    output logic                      oRX_VALID,
    input  logic                      iRX_READY,
    input  logic [DATA_WIDTH-1:0]     iTX_DATA,
    input  logic                      iTX_VALID,
    output logic                      oTX_READY,
    output logic [clog2(RX_DEPTH):0]  oRX_LEVEL,
    output state_t                    oDBG_STATE
);

    localparam int RXLW   = clog2(RX_DEPTH) + 1;
    localparam int TXLW   = clog2(TX_DEPTH) + 1;
    localparam int CNT_W  = 8;
    localparam int SIWU_W = (SIWU_IDLE < 2) ? 1 : clog2(SIWU_IDLE + 1);

    logic [SYNC_STAGES-1:0] r_rxf_sync;
    logic [SYNC_STAGES-1:0] r_txe_sync;
    state_t                 r_state;
    state_t                 w_state_nx;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nx;
    logic                   r_rr;
    logic                   w_rr_nx;
    logic                   w_tx_pop;
    logic                   w_capture;
    logic                   r_rx_push;
    logic [DATA_WIDTH-1:0]  r_rx_capt;
    logic                   r_rd_n;
    logic                   r_wr_n;
    logic                   r_oe_n;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_siwu_n;
    logic [SIWU_W-1:0]      r_siwu_cnt;
    logic                   r_siwu_armed;
    logic                   w_rxf_n;
    logic                   w_txe_n;
    logic                   w_rx_empty;
    logic [RXLW-1:0]        w_rx_level;
    logic [RXLW:0]          w_rx_used;
    logic                   w_tx_empty;
    logic [TXLW-1:0]        w_tx_level;
    logic [DATA_WIDTH-1:0]  w_tx_head;
    logic                   w_rx_elig;
    logic                   w_tx_elig;

    assign w_rxf_n = r_rxf_sync[SYNC_STAGES-1];
    assign w_txe_n = r_txe_sync[SYNC_STAGES-1];

    // Status synchronisers; reset to the inactive (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxf_sync <= '1;
            r_txe_sync <= '1;
        end else begin
            r_rxf_sync <= {r_rxf_sync[SYNC_STAGES-2:0], iFIFO_RXF_n};
            r_txe_sync <= {r_txe_sync[SYNC_STAGES-2:0], iFIFO_TXE_n};
        end
    end

    ft245_fifo_bridge_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_rx_push),
        .i_data  (r_rx_capt),
        .i_pop   (oRX_VALID && iRX_READY),
        .o_data  (oRX_DATA),
        .o_empty (w_rx_empty),
        .o_level (w_rx_level)
    );

    ft245_fifo_bridge_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (iTX_VALID && oTX_READY),
        .i_data  (iTX_DATA),
        .i_pop   (w_tx_pop),
        .o_data  (w_tx_head),
        .o_empty (w_tx_empty),
        .o_level (w_tx_level)
    );

    assign oRX_VALID  = !w_rx_empty;
    assign oRX_LEVEL  = w_rx_level;
    assign oTX_READY  = (w_tx_level != TXLW'(TX_DEPTH));
    assign oDBG_STATE = r_state;

    // A captured byte still waiting for its push already owns a slot.
    assign w_rx_used = {1'b0, w_rx_level} + {{RXLW{1'b0}}, r_rx_push};
    assign w_rx_elig = !w_rxf_n && (w_rx_used < (RXLW + 1)'(RX_DEPTH));
    assign w_tx_elig = !w_txe_n && !w_tx_empty;

    // Sequencer state, strobe counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rr    <= RR_RX;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_rr    <= w_rr_nx;
        end
    end

    // Next-state: arbitration in IDLE, then fixed-length strobe phases.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_rr_nx    = r_rr;
        w_tx_pop   = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nx = '0;
                if (w_rx_elig && (!w_tx_elig || (r_rr == RR_RX))) begin
                    w_state_nx = ST_RD;
                    w_rr_nx    = RR_TX;
                end else if (w_tx_elig) begin
                    w_state_nx = ST_WR_SETUP;
                    w_tx_pop   = 1'b1;
                    w_rr_nx    = RR_RX;
                end
            end
            ST_RD: begin
                if (r_cnt == CNT_W'(RD_PULSE - 1)) begin
                    w_capture  = 1'b1;
                    w_cnt_nx   = '0;
                    w_state_nx = (TURN_CYC > 0) ? ST_TURN : ST_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            ST_WR_SETUP: begin
                w_cnt_nx   = '0;
                w_state_nx = ST_WR;
            end
            ST_WR: begin
                if (r_cnt == CNT_W'(WR_PULSE - 1)) begin
                    w_cnt_nx   = '0;
                    w_state_nx = (TURN_CYC > 0) ? ST_TURN : ST_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            ST_TURN: begin
                if (r_cnt == CNT_W'(TURN_CYC - 1)) begin
                    w_cnt_nx   = '0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nx   = '0;
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Pin outputs are registered from the next state so they change with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_data    <= '0;
            r_rx_push <= 1'b0;
            r_rx_capt <= '0;
        end else begin
            r_rd_n    <= (w_state_nx != ST_RD);
            r_wr_n    <= (w_state_nx != ST_WR);
            r_oe_n    <= !((w_state_nx == ST_WR_SETUP) || (w_state_nx == ST_WR));
            r_rx_push <= w_capture;
            if (w_tx_pop) begin
                r_data <= w_tx_head;
            end
            if (w_capture) begin
                r_rx_capt <= iFIFO_DATA;
            end
        end
    end

    // Send-immediate timer: one pulse per TX burst after the buffer drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_siwu_n     <= 1'b1;
            r_siwu_cnt   <= '0;
            r_siwu_armed <= 1'b0;
        end else begin
            r_siwu_n <= 1'b1;
            if (r_state == ST_WR) begin
                r_siwu_cnt   <= '0;
                r_siwu_armed <= 1'b1;
            end else if ((SIWU_IDLE != 0) && (r_state == ST_IDLE) && w_tx_empty && r_siwu_armed) begin
                r_siwu_cnt <= r_siwu_cnt + 1'b1;
                if (r_siwu_cnt == SIWU_W'(SIWU_IDLE - 1)) begin
                    r_siwu_n     <= 1'b0;
                    r_siwu_armed <= 1'b0;
                end
            end
        end
    end

    assign oFIFO_RD_n   = r_rd_n;
    assign oFIFO_WR_n   = r_wr_n;
    assign oFIFO_OE_n   = r_oe_n;
    assign oFIFO_DATA   = r_data;
    assign oFIFO_SIWU_n = r_siwu_n;

    // The bus is never driven while the read strobe is active.
    a_no_oe_during_rd: assert property (@(posedge clk) disable iff (rst) !(!r_oe_n && !r_rd_n));

endmodule

// File: tb/tb_ft245_fifo_bridge.sv
// Bench for ft245_fifo_bridge: FTDI pin model, stream drivers and scoreboards.
module tb_ft245_fifo_bridge;
    import ft245_fifo_bridge_pkg::*;

    localparam int DW        = 8;
    localparam int RX_DEPTH  = 16;
    localparam int TX_DEPTH  = 16;
    localparam int SYNC      = 2;
    localparam int RD_PULSE  = 3;
    localparam int WR_PULSE  = 3;
    localparam int TURN_CYC  = 1;
    localparam int SIWU_IDLE = 64;

    logic          clk;
    logic          rst;
    logic          rxf_n;
    logic          rd_n;
    logic          txe_n;
    logic          wr_n;
    logic [DW-1:0] fifo_din;
    logic [DW-1:0] fifo_dout;
    logic          oe_n;
    logic          siwu_n;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [4:0]    rx_level;
    state_t        dbg_state;

    ft245_fifo_bridge #(
        .DATA_WIDTH  (DW),
        .RX_DEPTH    (RX_DEPTH),
        .TX_DEPTH    (TX_DEPTH),
        .SYNC_STAGES (SYNC),
        .RD_PULSE    (RD_PULSE),
        .WR_PULSE    (WR_PULSE),
        .TURN_CYC    (TURN_CYC),
        .SIWU_IDLE   (SIWU_IDLE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .iFIFO_RXF_n  (rxf_n),
        .oFIFO_RD_n   (rd_n),
        .iFIFO_TXE_n  (txe_n),
        .oFIFO_WR_n   (wr_n),
        .iFIFO_DATA   (fifo_din),
        .oFIFO_DATA   (fifo_dout),
        .oFIFO_OE_n   (oe_n),
        .oFIFO_SIWU_n (siwu_n),
        .oRX_DATA     (rx_data),
        .oRX_VALID    (rx_valid),
        .iRX_READY    (rx_ready),
        .iTX_DATA     (tx_data),
        .iTX_VALID    (tx_valid),
        .oTX_READY    (tx_ready),
        .oRX_LEVEL    (rx_level),
        .oDBG_STATE   (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- FTDI model and scoreboards ----------------
    logic [DW-1:0] ftdi_bytes [64];
    int            ftdi_n = 0;     // bytes offered (main writes)
    int            ftdi_idx = 0;   // bytes delivered (model writes)
    logic          rx_en;
    logic [DW-1:0] exp_rx_q [$];
    logic [DW-1:0] exp_tx_q [$];
    logic          grant_log [$];  // 0 = read, 1 = write
    int  cyc = 0;
    int  rd_len = 0, wr_len = 0, last_rise = 0;
    int  rd_pulses = 0, wr_pulses = 0, rx_got = 0, oe_low_cycles = 0;
    int  bad_overlap = 0, bad_oe_wr = 0, bad_stable = 0, bad_setup = 0;
    int  siwu_pulses = 0, siwu_low_cycles = 0, siwu_delay = 0, last_wr_rise = 0;
    logic prev_rd = 1'b1, prev_wr = 1'b1, prev_oe = 1'b1, prev_siwu = 1'b1;
    logic [DW-1:0] wr_latched = '0;

    initial begin
        rxf_n    = 1'b1;
        fifo_din = '0;
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_rx_q.delete();
            exp_tx_q.delete();
        end else begin
            if (rx_valid && rx_ready) begin
                if (exp_rx_q.size() == 0) check("rx_unexpected", 1, 0);
                else check("rx_data", rx_data, exp_rx_q.pop_front());
                rx_got++;
            end
            if (tx_valid && tx_ready) exp_tx_q.push_back(tx_data);
        end
        if (!oe_n) oe_low_cycles++;
        if (!oe_n && !rd_n) bad_overlap++;
        // read strobe
        if (!rd_n) begin
            if (prev_rd) begin
                rd_len = 0;
                if (!rst) begin
                    grant_log.push_back(1'b0);
                    check("rd_turn_gap", (cyc - last_rise) >= TURN_CYC + 1, 1);
                end
            end
            rd_len++;
        end else if (!prev_rd) begin
            if (!rst) begin
                check("rd_width", rd_len, RD_PULSE);
                if (ftdi_idx < ftdi_n) begin
                    exp_rx_q.push_back(ftdi_bytes[ftdi_idx]);
                    ftdi_idx++;
                end
                rd_pulses++;
            end
            last_rise = cyc;
        end
        // write strobe
        if (!wr_n) begin
            if (oe_n) bad_oe_wr++;
            if (prev_wr) begin
                wr_len = 0;
                wr_latched = fifo_dout;
                if (prev_oe) bad_setup++;
                if (!rst) begin
                    grant_log.push_back(1'b1);
                    check("wr_turn_gap", (cyc - last_rise) >= TURN_CYC + 1, 1);
                end
            end else if (fifo_dout !== wr_latched) begin
                bad_stable++;
            end
            wr_len++;
        end else if (!prev_wr) begin
            if (!rst) begin
                check("wr_width", wr_len, WR_PULSE);
                if (exp_tx_q.size() == 0) check("tx_unexpected", 1, 0);
                else check("tx_byte", wr_latched, exp_tx_q.pop_front());
                wr_pulses++;
            end
            last_rise = cyc;
            last_wr_rise = cyc;
        end
        // send-immediate
        if (!siwu_n) begin
            siwu_low_cycles++;
            if (prev_siwu && !rst) begin
                siwu_pulses++;
                siwu_delay = cyc - last_wr_rise;
            end
        end
        // status/data pins seen by the bridge
        rxf_n    = rd_n ? !(rx_en && (ftdi_idx < ftdi_n)) : 1'b1;
        fifo_din = (ftdi_idx < 64) ? ftdi_bytes[ftdi_idx] : '0;
        prev_rd   = rd_n;
        prev_wr   = wr_n;
        prev_oe   = oe_n;
        prev_siwu = siwu_n;
    end

    // ---------------- drivers ----------------
    task automatic offer(input logic [DW-1:0] b);
        ftdi_bytes[ftdi_n] = b;
        ftdi_n++;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; rx_en = 1'b0; txe_n = 1'b1; rx_ready = 1'b0; tx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ftdi_n = ftdi_idx;
        rst = 1'b0;
    endtask

    task automatic send_tx(input logic [DW-1:0] b);
        logic done;
        done = 1'b0;
        @(posedge clk); #1;
        tx_data = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            if (tx_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
        if (!done) check("tx_accept_timeout", 1, 0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- sequence ----------------
    int base_rd, base_wr, base_got, base_oe, base_log, base_sp, base_sl;
    logic seen;

    initial begin
        rst = 1'b1; rx_en = 1'b0; txe_n = 1'b1; rx_ready = 1'b0;
        tx_valid = 1'b0; tx_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset during a read strobe
        offer(8'h77);
        rx_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (!rd_n) seen = 1'b1;
        end
        check("t1_rd_started", seen, 1);
        @(posedge clk); #1;
        rst = 1'b1; rx_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t1_rd_n", rd_n, 1);
        check("t1_wr_n", wr_n, 1);
        check("t1_oe_n", oe_n, 1);
        check("t1_siwu_n", siwu_n, 1);
        check("t1_fifo_dout", fifo_dout, 0);
        check("t1_rx_valid", rx_valid, 0);
        check("t1_rx_level", rx_level, 0);
        check("t1_tx_ready", tx_ready, 1);
        check("t1_state", dbg_state, ST_IDLE);
        ftdi_n = ftdi_idx;
        @(posedge clk); #1 rst = 1'b0;

        // 2: three reads streamed out in order
        base_rd = rd_pulses; base_got = rx_got;
        offer(8'h11); offer(8'h22); offer(8'h33);
        rx_ready = 1'b1; rx_en = 1'b1;
        for (int i = 0; i < 300 && rx_got - base_got < 3; i++) @(negedge clk);
        check("t2_rx_count", rx_got - base_got, 3);
        check("t2_rd_pulses", rd_pulses - base_rd, 3);
        check("t2_exp_empty", exp_rx_q.size(), 0);

        // 3: back-pressure stops reads at buffer depth
        do_reset();
        base_rd = rd_pulses; base_got = rx_got;
        for (int i = 0; i < 20; i++) offer(8'(8'h40 + i));
        rx_en = 1'b1;
        wait_cycles(300);
        check("t3_rd_16", rd_pulses - base_rd, 16);
        check("t3_level_full", rx_level, 16);
        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
        wait_cycles(60);
        check("t3_one_pop", rx_got - base_got, 1);
        check("t3_rd_17", rd_pulses - base_rd, 17);
        check("t3_level_refill", rx_level, 16);
        rx_ready = 1'b1;
        for (int i = 0; i < 600 && rx_got - base_got < 20; i++) @(negedge clk);
        check("t3_rx_count", rx_got - base_got, 20);
        check("t3_exp_empty", exp_rx_q.size(), 0);

        // 4: two writes with bus-enable framing
        do_reset();
        base_wr = wr_pulses; base_oe = oe_low_cycles;
        txe_n = 1'b0;
        send_tx(8'hA5);
        send_tx(8'h5A);
        for (int i = 0; i < 100 && wr_pulses - base_wr < 2; i++) @(negedge clk);
        wait_cycles(5);
        check("t4_wr_pulses", wr_pulses - base_wr, 2);
        check("t4_oe_cycles", oe_low_cycles - base_oe, 2 * (1 + WR_PULSE));
        check("t4_exp_empty", exp_tx_q.size(), 0);

        // 5: both sides eligible -> alternating grants
        do_reset();
        base_log = grant_log.size();
        send_tx(8'hA1);
        send_tx(8'hA2);
        offer(8'hB1); offer(8'hB2);
        rx_ready = 1'b1;
        @(posedge clk); #1;
        txe_n = 1'b0; rx_en = 1'b1;
        for (int i = 0; i < 300 && grant_log.size() - base_log < 4; i++) @(negedge clk);
        check("t5_grant_count", grant_log.size() - base_log >= 4, 1);
        if (grant_log.size() - base_log >= 4) begin
            check("t5_grant0", grant_log[base_log + 0], 0);
            check("t5_grant1", grant_log[base_log + 1], 1);
            check("t5_grant2", grant_log[base_log + 2], 0);
            check("t5_grant3", grant_log[base_log + 3], 1);
        end
        wait_cycles(20);

        // 6: send-immediate after a lone write
        do_reset();
        base_wr = wr_pulses; base_sp = siwu_pulses; base_sl = siwu_low_cycles;
        txe_n = 1'b0;
        send_tx(8'hC3);
        for (int i = 0; i < 100 && wr_pulses - base_wr < 1; i++) @(negedge clk);
        check("t6_wr_pulse", wr_pulses - base_wr, 1);
        wait_cycles(250);
        check("t6_siwu_pulses", siwu_pulses - base_sp, 1);
        check("t6_siwu_width", siwu_low_cycles - base_sl, 1);
        check("t6_siwu_delay_window",
              (siwu_delay >= SIWU_IDLE) && (siwu_delay <= SIWU_IDLE + TURN_CYC + 1), 1);

        // protocol invariants over the whole run
        check("oe_rd_overlap", bad_overlap, 0);
        check("oe_high_in_wr", bad_oe_wr, 0);
        check("wr_setup_missing", bad_setup, 0);
        check("wr_data_unstable", bad_stable, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
